// File: rtl/vector_result_collector_96.sv
// Purpose : collects N_WORDS serial result words into a parallel vector for the next RNN stage.
// Latency : vec_valid rises one cycle after the final accepted beat (res_done or word N_WORDS).
// Backpr. : res_ready drops while a frame is held; it returns the cycle after vec_ready is taken.
//
// Ports:
//   clk, rst_n                 - clock; rst_n is an asynchronous reset, asserted HIGH
//   res_valid/res_data/res_done - producer word stream, res_done marks the final word
//   res_ready                  - combinational, high only in FILL and out of reset
//   vec_out/vec_valid/vec_ready - assembled frame and its handshake to the consumer
//   word_cnt                   - live count in FILL, frame length while held
//   err_short/err_long         - sticky framing errors, cleared only by reset
module vector_result_collector_96 #(
   parameter int N_WORDS = 96,
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_data,
   input  logic             res_done,
   output logic             res_ready,
   output logic [WIDTH-1:0] vec_out [N_WORDS-1:0],
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [CNT_W-1:0] word_cnt,
   output logic             err_short,
   output logic             err_long
);

   typedef enum logic {FILL, HOLD} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] vec_q [N_WORDS-1:0];
   logic [WIDTH-1:0] vec_d [N_WORDS-1:0];
   logic             err_short_q, err_short_d;
   logic             err_long_q, err_long_d;
   logic             accept;

   // Ready depends only on state (and reset), never on res_valid.
   assign res_ready = !rst_n && (state_q == FILL);
   assign accept    = res_valid && res_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vec_d       = vec_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               vec_d[cnt_q] = res_data;
               cnt_d        = cnt_q + 1'b1;
               // The counter stops at N_WORDS: the last slot always closes the frame.
               if (res_done || (cnt_q == LAST)) begin
                  state_d = HOLD;
               end
               if (res_done && (cnt_q != LAST)) begin
                  err_short_d = 1'b1;
               end
               if (!res_done && (cnt_q == LAST)) begin
                  err_long_d = 1'b1;
               end
            end
         end
         HOLD: begin
            // cnt holds the frame length until the consumer takes the vector.
            if (vec_ready) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         for (int i = 0; i < N_WORDS; i++) begin
            vec_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         vec_q       <= vec_d;
      end
   end

   assign vec_out   = vec_q;
   assign vec_valid = (state_q == HOLD);
   assign word_cnt  = cnt_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;

endmodule

// File: tb/tb_vector_result_collector_96.sv
module tb_vector_result_collector_96;

   localparam int N  = 96;
   localparam int W  = 32;
   localparam int CW = 7;

   typedef logic [N*W-1:0] frame_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          res_valid = 1'b0;
   logic [W-1:0]  res_data = '0;
   logic          res_done = 1'b0;
   logic          res_ready;
   logic [W-1:0]  vec_out [N-1:0];
   logic          vec_valid;
   logic          vec_ready = 1'b0;
   logic [CW-1:0] word_cnt;
   logic          err_short;
   logic          err_long;

   vector_result_collector_96 #(.N_WORDS(N), .WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .res_valid(res_valid), .res_data(res_data), .res_done(res_done), .res_ready(res_ready),
      .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .word_cnt(word_cnt), .err_short(err_short), .err_long(err_long)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model and scoreboard
   logic [W-1:0] m_vec [N];
   int           m_cnt = 0;
   bit           m_es = 0;
   bit           m_el = 0;
   frame_t       frame_q [$];
   int           fcnt_q [$];
   bit           fes_q [$];
   bit           fel_q [$];
   int           hold_cycles = 0;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_vec[i] = '0;
      m_cnt = 0;
      m_es  = 0;
      m_el  = 0;
   endtask

   task automatic send_beat(input logic [31:0] d, input bit done);
      int     t;
      bit     fin;
      int     flen;
      frame_t f;
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = d;
      res_done  = done;
      t = 0;
      while (!res_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!res_ready) begin
         check_eq("accept_timeout", res_ready, 1);
         res_valid = 1'b0;
         return;
      end
      @(posedge clk);
      m_vec[m_cnt] = d;
      m_cnt++;
      fin = done || (m_cnt == N);
      if (done && m_cnt < N) m_es = 1;
      if (!done && m_cnt == N) m_el = 1;
      flen = m_cnt;
      if (fin) begin
         for (int i = 0; i < N; i++) f[i*W +: W] = m_vec[i];
         frame_q.push_back(f);
         fcnt_q.push_back(m_cnt);
         fes_q.push_back(m_es);
         fel_q.push_back(m_el);
         m_cnt = 0;
      end
      #1;
      check_eq(fin ? "latency_valid" : "fill_valid_low", vec_valid, fin);
      check_eq("live_word_cnt", word_cnt, flen);
   endtask

   task automatic idle();
      @(negedge clk);
      res_valid = 1'b0;
      res_done  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((frame_q.size() != 0 || vec_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain", (frame_q.size() == 0) && !vec_valid, 1);
   endtask

   // Consumer: checks each presented frame against the scoreboard, then releases it
   initial begin
      frame_t cur;
      int     ecnt;
      bit     ees, eel;
      int     wcnt;
      bit     seen;
      seen = 0;
      wcnt = 0;
      cur  = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            vec_ready = 1'b0;
            seen = 0;
         end else if (vec_ready) begin
            vec_ready = 1'b0;
            seen = 0;
            check_eq("valid_drop", vec_valid, 0);
            check_eq("ready_after_release", res_ready, 1);
         end else begin
            if (vec_valid && !seen) begin
               seen = 1;
               wcnt = 0;
               if (frame_q.size() == 0) begin
                  check_eq("unexpected_frame", vec_valid, 0);
               end else begin
                  cur  = frame_q.pop_front();
                  ecnt = fcnt_q.pop_front();
                  ees  = fes_q.pop_front();
                  eel  = fel_q.pop_front();
                  check_eq("word_cnt", word_cnt, ecnt);
                  check_eq("err_short", err_short, ees);
                  check_eq("err_long", err_long, eel);
                  for (int i = 0; i < N; i++) begin
                     check_eq($sformatf("vec_out[%0d]", i), vec_out[i], cur[i*W +: W]);
                  end
               end
            end
            if (seen) begin
               if (wcnt >= hold_cycles) begin
                  vec_ready = 1'b1;
               end else begin
                  check_eq("bp_ready_low", res_ready, 0);
                  check_eq("bp_vec0_stable", vec_out[0], cur[W-1:0]);
                  check_eq("bp_vec95_stable", vec_out[N-1], cur[(N-1)*W +: W]);
                  wcnt++;
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      // Reset state
      #12;
      check_eq("rst_res_ready", res_ready, 0);
      check_eq("rst_vec_valid", vec_valid, 0);
      check_eq("rst_word_cnt", word_cnt, 0);
      check_eq("rst_err_short", err_short, 0);
      check_eq("rst_err_long", err_long, 0);
      check_eq("rst_vec5", vec_out[5], 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("ready_after_reset", res_ready, 1);

      // Normal back-to-back frame
      for (int i = 0; i < N; i++) send_beat(32'h100 + i, i == N-1);
      idle();
      drain();

      // Back-pressure: pending word waits through a 10-cycle hold
      hold_cycles = 10;
      for (int i = 0; i < N; i++) send_beat(32'h200 + i, i == N-1);
      send_beat(32'h300, 0);
      hold_cycles = 0;
      for (int i = 1; i < N; i++) send_beat(32'h300 + i, i == N-1);
      idle();
      drain();

      // Gapped input, same data as the normal frame
      for (int i = 0; i < N; i++) begin
         send_beat(32'h100 + i, i == N-1);
         idle();
      end
      drain();

      // Short frame, then a normal frame with err_short still set
      for (int i = 0; i < 40; i++) send_beat(32'h400 + i, i == 39);
      idle();
      drain();
      for (int i = 0; i < N; i++) send_beat(32'h500 + i, i == N-1);
      idle();
      drain();
      check_eq("err_short_sticky", err_short, 1);

      // Long frame: 97th word back-pressured, then becomes word 0 of the next frame
      hold_cycles = 5;
      for (int i = 0; i < N; i++) send_beat(32'h600 + i, 0);
      send_beat(32'h700, 0);
      hold_cycles = 0;
      for (int i = 1; i < N; i++) send_beat(32'h700 + i, i == N-1);
      idle();
      drain();

      // Asynchronous reset mid-frame
      for (int i = 0; i < 50; i++) send_beat(32'h800 + i, 0);
      @(posedge clk);
      #3;
      rst_n     = 1'b1;
      res_valid = 1'b0;
      res_done  = 1'b0;
      #1;
      check_eq("arst_vec0", vec_out[0], 0);
      check_eq("arst_vec49", vec_out[49], 0);
      check_eq("arst_word_cnt", word_cnt, 0);
      check_eq("arst_err_short", err_short, 0);
      check_eq("arst_err_long", err_long, 0);
      check_eq("arst_res_ready", res_ready, 0);
      check_eq("arst_vec_valid", vec_valid, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) send_beat(32'hA00 + i, i == N-1);
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_result_collector_96.md
Name: vector_result_collector_96

Overview:
- Receive end of the serial result stream produced by the vector-linear engines: one 32-bit result word per accepted beat, with a done strobe on the final word.
- Assembles 96 words into a parallel vector and holds it for the next RNN stage, such as gate split or activation.
- Holds the vector under a valid/ready handshake and back-pressures the producer while the vector is held.
- Flags frames that are too short or that overrun the expected length.

Parameters:
- N_WORDS, 96: words per frame.
- WIDTH, 32: bits per word.
- CNT_W, 7: counter width; must satisfy 2**CNT_W > N_WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-HIGH (asserted = 1). The codebase name is kept; the polarity is high.
- res_valid  input  1  producer presents a word this cycle.
- res_data  input  WIDTH  result word.
- res_done  input  1  qualifies the final word of a frame; sampled only when res_valid && res_ready.
- res_ready  output  1  collector can accept a word.
- vec_out  output  WIDTH x N_WORDS (unpacked [N_WORDS-1:0])  assembled vector; vec_out[i] is the i-th accepted word.
- vec_valid  output  1  vec_out holds a complete frame.
- vec_ready  input  1  downstream consumes the frame.
- word_cnt  output  CNT_W  words captured in the current or held frame.
- err_short  output  1  sticky: res_done arrived before word N_WORDS.
- err_long  output  1  sticky: word N_WORDS accepted without res_done.

Behaviour:
- Reset values (async, rst_n=1): state=FILL, word counter=0, all vec_out entries=0, vec_valid=0, res_ready=0 while reset is asserted then 1 in FILL, err_short=0, err_long=0.
- Beat definition: a beat is accepted when res_valid && res_ready at a rising clock edge.
- res_ready is combinational: 1 in FILL, 0 in HOLD. It has no dependency on res_valid.
- FILL state: on each accepted beat, vec_out[cnt] <= res_data and cnt <= cnt+1.
  - If the beat has res_done=1, or cnt==N_WORDS-1: go to HOLD, vec_valid<=1, word_cnt<=cnt+1.
- Boundary: res_done with cnt+1 < N_WORDS sets err_short=1. The frame is still presented. Unwritten entries keep the value from the previous frame; the consumer must use word_cnt.
- Boundary: cnt==N_WORDS-1 accepted with res_done=0 sets err_long=1 and the frame is presented. Any further words arrive in HOLD and are back-pressured; they are never dropped silently.
- HOLD state: vec_out, word_cnt and vec_valid are stable.
  - On vec_valid && vec_ready: vec_valid<=0, cnt<=0, go to FILL. res_ready rises in the following cycle.
  - Minimum one idle cycle between frames on the input side.
- Simultaneous events: res_valid during the vec_ready cycle in HOLD is not accepted (res_ready=0). That word is taken in the next cycle.
- word_cnt in FILL tracks the live count.
- Latency: the last word accepted at edge k gives vec_valid=1 visible after edge k, so the output is valid one cycle after the final beat.
- Error flags are sticky and clear only on reset. They do not block operation.
- Reset mid-frame: partial frame discarded, all state to reset values, next beat is word 0.
- No arithmetic on data. The counter never exceeds N_WORDS.

Test Plan:
- Normal frame: 96 beats back-to-back with res_data=i+0x100 and res_done on beat 95 -> vec_valid=1 one cycle after beat 95, vec_out[i]=0x100+i, word_cnt=96, both errors 0.
- Back-pressure: hold vec_ready=0 for 10 cycles after a frame with res_valid=1 -> res_ready=0 throughout, vec_out unchanged. Raise vec_ready -> frame released, res_ready=1 in the next cycle, and the pending word is captured as vec_out[0] of the next frame.
- Gapped input: res_valid toggled 1,0,1,0 over 96 words -> identical vec_out to the back-to-back case, completing at the 96th accepted beat.
- Short frame: res_done on word 40 -> vec_valid=1, word_cnt=40, err_short=1, err_long=0. err_short stays 1 after a following normal frame.
- Long frame: 96 words with res_done=0 -> vec_valid=1, word_cnt=96, err_long=1, and the 97th word is back-pressured.
- Async reset: assert rst_n=1 after word 50, mid-clock, then release and send a full frame -> outputs zero immediately on assertion, and the new frame's vec_out[0] is the first post-reset word.
